prefetch_queue: RTL

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: byte prefetch buffer between a read bus and an instruction decoder.
//
// Fetches aligned BUS_BYTES-wide beats starting at a linear fetch address and
// appends the returned bytes to a circular byte queue of QUEUE_BYTES entries.
// The oldest 16 queued bytes are presented as a window. The decoder retires
// bytes from the front of the window with consume/consume_bytes. A flush
// empties the queue and restarts fetching at a new (possibly unaligned) address.
//
// Ports:
//   clock, reset         clock (rising edge), asynchronous active-low reset
//   flush, flush_address discard queue, restart fetch at flush_address
//   bus_vaild            read request presented (held until bus_ready)
//   bus_ready, bus_data  beat completes this cycle with read data
//   bus_address          aligned beat address
//   window[0:15]         oldest 16 queued bytes, window[0] is oldest
//   window_count         valid window bytes, min(occupancy, 16)
//   window_address       linear address of window[0]
//   consume, consume_bytes  retire 1..16 bytes from the front of the window
module prefetch_queue #(
    parameter int unsigned QUEUE_BYTES   = 32,
    parameter int unsigned BUS_BYTES     = 4,
    parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [31:0]            flush_address,
    output logic                   bus_vaild,
    input  logic                   bus_ready,
    output logic [31:0]            bus_address,
    input  logic [8*BUS_BYTES-1:0] bus_data,
    output logic [7:0]             window [0:15],
    output logic [4:0]             window_count,
    output logic [31:0]            window_address,
    input  logic                   consume,
    input  logic [4:0]             consume_bytes
);

    localparam int unsigned      PtrW      = $clog2(QUEUE_BYTES);
    localparam int unsigned      OccW      = PtrW + 1;
    localparam logic [31:0]      AlignMask = 32'(BUS_BYTES - 1);
    localparam logic [OccW-1:0]  Capacity  = OccW'(QUEUE_BYTES);
    localparam logic [OccW-1:0]  BeatBytes = OccW'(BUS_BYTES);

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StDiscard
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       bus_address_q, bus_address_d;
    logic [31:0]       restart_q, restart_d;       // aligned restart address while discarding
    logic [2:0]        skip_q, skip_d;             // leading bytes to drop from next beat
    logic [OccW-1:0]   occ_q, occ_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]       window_address_q, window_address_d;

    logic [7:0]        queue_mem [QUEUE_BYTES];

    logic [31:0]       flush_aligned;
    logic [4:0]        cons_bytes;
    logic [OccW-1:0]   app_bytes;
    logic              accept;
    logic [PtrW-1:0]   wr_ptr;

    assign bus_vaild      = (state_q != StIdle);
    assign bus_address    = bus_address_q;
    assign window_address = window_address_q;
    assign flush_aligned  = flush_address & ~AlignMask;
    assign wr_ptr         = rd_ptr_q + PtrW'(occ_q);

    // A beat only carries queue data in StRequest; a flush on the same edge wins.
    assign accept    = (state_q == StRequest) && bus_ready && !flush;
    assign app_bytes = accept ? (BeatBytes - OccW'(skip_q)) : '0;

    always_comb begin
        window_count = (occ_q >= OccW'(16)) ? 5'd16 : 5'(occ_q);
    end

    // Retire no more than what the window currently shows.
    always_comb begin
        cons_bytes = 5'd0;
        if (consume) begin
            cons_bytes = (consume_bytes < window_count) ? consume_bytes : window_count;
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            window[i] = queue_mem[rd_ptr_q + PtrW'(i)];
        end
    end

    always_comb begin
        state_d          = state_q;
        bus_address_d    = bus_address_q;
        restart_d        = restart_q;
        skip_d           = skip_q;
        occ_d            = occ_q;
        rd_ptr_d         = rd_ptr_q;
        window_address_d = window_address_q;

        if (flush) begin
            occ_d            = '0;
            window_address_d = flush_address;
            skip_d           = 3'(flush_address & AlignMask);
            unique case (state_q)
                StIdle: begin
                    state_d       = StRequest;
                    bus_address_d = flush_aligned;
                end
                StRequest, StDiscard: begin
                    if (bus_ready) begin
                        state_d       = StRequest;
                        bus_address_d = flush_aligned;
                    end else begin
                        // The outstanding request must complete before restarting.
                        state_d   = StDiscard;
                        restart_d = flush_aligned;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else begin
            occ_d            = occ_q + app_bytes - OccW'(cons_bytes);
            rd_ptr_d         = rd_ptr_q + PtrW'(cons_bytes);
            window_address_d = window_address_q + {27'd0, cons_bytes};
            unique case (state_q)
                StIdle: begin
                    if ((Capacity - occ_q) >= BeatBytes) begin
                        state_d = StRequest;
                    end
                end
                StRequest: begin
                    if (bus_ready) begin
                        bus_address_d = bus_address_q + 32'(BUS_BYTES);
                        skip_d        = 3'd0;
                        state_d       = ((Capacity - occ_d) >= BeatBytes) ? StRequest : StIdle;
                    end
                end
                StDiscard: begin
                    if (bus_ready) begin
                        bus_address_d = restart_q;
                        state_d       = StRequest;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            bus_address_q    <= RESET_ADDRESS & ~AlignMask;
            restart_q        <= RESET_ADDRESS & ~AlignMask;
            skip_q           <= 3'(RESET_ADDRESS & AlignMask);
            occ_q            <= '0;
            rd_ptr_q         <= '0;
            window_address_q <= RESET_ADDRESS;
        end else begin
            state_q          <= state_d;
            bus_address_q    <= bus_address_d;
            restart_q        <= restart_d;
            skip_q           <= skip_d;
            occ_q            <= occ_d;
            rd_ptr_q         <= rd_ptr_d;
            window_address_q <= window_address_d;
        end
    end

    // Bytes below the fetch address are skipped; the rest pack in at the tail.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int j = 0; j < int'(BUS_BYTES); j++) begin
                if (j >= int'(skip_q)) begin
                    queue_mem[wr_ptr + PtrW'(j) - PtrW'(skip_q)] <= bus_data[8*j +: 8];
                end
            end
        end
    end

endmodule
